// File: rtl/scfifo.sv
`default_nettype none
// ============================================================================
// Module   : scfifo
// Brief    : Single-clock show-ahead FIFO with fill-level and almost flags.
//            Define SCFIFO_ASSERT_EN to compile in overflow/underflow messages.
// Revision : 1.0 - initial release
// ============================================================================
module scfifo #(
  parameter int    lpm_width               = 8,
  parameter int    lpm_widthu              = 3,
  parameter int    lpm_numwords            = 8,
  parameter string lpm_showahead           = "ON",
  parameter string overflow_checking       = "OFF",
  parameter string underflow_checking      = "OFF",
  parameter int    almost_full_value       = 6,
  parameter int    almost_empty_value      = 2,
  parameter string add_ram_output_register = "OFF",
  parameter string intended_device_family  = "Stratix",
  parameter string use_eab                 = "ON",
  parameter string lpm_type                = "scfifo"
) (
  input  logic                  clock,
  input  logic                  sclr,
  input  logic [lpm_width-1:0]  data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [lpm_width-1:0]  q,
  output logic                  empty,
  output logic                  full,
  output logic [lpm_widthu-1:0] usedw,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam logic [lpm_widthu:0] c_FULL_CNT = lpm_numwords[lpm_widthu:0];
  localparam logic [lpm_widthu:0] c_AF_CNT   = almost_full_value[lpm_widthu:0];
  localparam logic [lpm_widthu:0] c_AE_CNT   = almost_empty_value[lpm_widthu:0];
  localparam bit c_OVF_CHK = (overflow_checking == "ON");
  localparam bit c_UNF_CHK = (underflow_checking == "ON");
  localparam bit c_COMPAT_SET = (add_ram_output_register != "") && (intended_device_family != "")
                              && (use_eab != "") && (lpm_type != "");

  // Only show-ahead mode with a power-of-two depth is implemented.
  if ((lpm_showahead != "ON") || (lpm_numwords != (1 << lpm_widthu)) || !c_COMPAT_SET) begin : g_bad_cfg
    $error("scfifo: unsupported parameter configuration");
  end

  logic [lpm_width-1:0]  r_mem [lpm_numwords];
  logic [lpm_widthu-1:0] r_rd_ptr;
  logic [lpm_widthu-1:0] r_wr_ptr;
  logic [lpm_widthu:0]   r_count;
  logic [lpm_width-1:0]  r_q;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_we;
  logic                  w_re;
  logic [lpm_widthu-1:0] w_rd_nxt;
  logic [lpm_widthu:0]   w_cnt_nxt;
  logic [lpm_width-1:0]  w_head_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL_CNT);
  assign w_we    = wrreq & ~(w_full  & c_OVF_CHK);
  assign w_re    = rdreq & ~(w_empty & c_UNF_CHK);

  always_comb begin
    w_rd_nxt  = r_rd_ptr;
    w_cnt_nxt = r_count;
    if (w_re) begin
      w_rd_nxt = r_rd_ptr + 1'b1;
    end
    if (w_we && !w_re) begin
      w_cnt_nxt = r_count + 1'b1;
    end else if (!w_we && w_re) begin
      w_cnt_nxt = r_count - 1'b1;
    end
  end

  // Next head word: forward incoming data when it lands exactly at the new head.
  assign w_head_nxt = (w_we && (r_wr_ptr == w_rd_nxt)) ? data : r_mem[w_rd_nxt];

  always_ff @(posedge clock) begin
    if (w_we && !sclr) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_q      <= '0;
    end else begin
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      // q holds its last value once the FIFO drains.
      if (w_cnt_nxt != '0) begin
        r_q <= w_head_nxt;
      end
    end
  end

  assign q            = r_q;
  assign empty        = w_empty;
  assign full         = w_full;
  assign usedw        = r_count[lpm_widthu-1:0];
  assign almost_full  = (r_count >= c_AF_CNT);
  assign almost_empty = (r_count <  c_AE_CNT);

`ifdef SCFIFO_ASSERT_EN
  always_ff @(posedge clock) begin
    if (!sclr && wrreq && w_full) begin
      $display("error - fifo overflow");
    end
    if (!sclr && rdreq && w_empty) begin
      $display("error - fifo underflow");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_scfifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_scfifo
// Brief    : Directed and random checks of scfifo against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scfifo;

  logic       clock = 1'b0;
  logic       sclr  = 1'b1;
  logic [7:0] data  = 8'h00;
  logic       wrreq = 1'b0;
  logic       rdreq = 1'b0;
  logic [7:0] q;
  logic       empty;
  logic       full;
  logic [2:0] usedw;
  logic       almost_full;
  logic       almost_empty;

  int n_asrt = 0;
  int n_fail = 0;

  logic [7:0] mq[$];
  logic [7:0] qexp = 8'h00;

  scfifo #(
    .lpm_width          (8),
    .lpm_widthu         (3),
    .lpm_numwords       (8),
    .lpm_showahead      ("ON"),
    .overflow_checking  ("ON"),
    .underflow_checking ("ON"),
    .almost_full_value  (6),
    .almost_empty_value (2)
  ) dut (
    .clock        (clock),
    .sclr         (sclr),
    .data         (data),
    .wrreq        (wrreq),
    .rdreq        (rdreq),
    .q            (q),
    .empty        (empty),
    .full         (full),
    .usedw        (usedw),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: a bounded queue with request gating at the limits.
  task automatic model(input logic w, input logic [7:0] d, input logic r, input logic s);
    bit do_w;
    bit do_r;
    if (s) begin
      mq.delete();
      qexp = 8'h00;
    end else begin
      do_w = w && (mq.size() != 8);
      do_r = r && (mq.size() != 0);
      if (do_r) void'(mq.pop_front());
      if (do_w) mq.push_back(d);
      if (mq.size() != 0) qexp = mq[0];
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == 8));
    chk("usedw", 32'(usedw), 32'(n % 8));
    chk("almost_full", 32'(almost_full), 32'(n >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(n < 2));
    chk("q", 32'(q), 32'(qexp));
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic s);
    wrreq = w;
    data  = d;
    rdreq = r;
    sclr  = s;
    @(posedge clock);
    model(w, d, r, s);
    #1;
    check_all();
  endtask

  initial begin
    // Reset and idle
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);

    // Three pushes then three pops
    step(1'b1, 8'h11, 1'b0, 1'b0);
    chk("first_q", 32'(q), 32'h11);
    chk("first_empty", 32'(empty), 32'h0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    chk("usedw3", 32'(usedw), 32'h3);
    chk("pop0", 32'(q), 32'h11);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop1", 32'(q), 32'h22);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop2", 32'(q), 32'h33);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drained_empty", 32'(empty), 32'h1);
    chk("drained_q_hold", 32'(q), 32'h33);

    // Fill to full, overflow attempt dropped
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_usedw", 32'(usedw), 32'h0);
    chk("fill_af", 32'(almost_full), 32'h1);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_full", 32'(full), 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk("fill_pop", 32'(q), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("fill_empty", 32'(empty), 32'h1);

    // Half full, simultaneous push/pop across pointer wrap
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'hB0 + i), 1'b1, 1'b0);
      chk("stream_usedw", 32'(usedw), 32'h4);
    end
    for (int i = 16; i < 20; i++) begin
      chk("stream_tail", 32'(q), 32'(8'hB0 + i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Clear with concurrent push
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    chk("sclr_empty", 32'(empty), 32'h1);
    chk("sclr_usedw", 32'(usedw), 32'h0);
    chk("sclr_q", 32'(q), 32'h0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("sclr_dropped", 32'(empty), 32'h1);

    // Gated underflow, then write+read on empty keeps the write
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_usedw", 32'(usedw), 32'h0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("unf_wr_q", 32'(q), 32'h77);
    chk("unf_wr_usedw", 32'(usedw), 32'h1);

    // Random traffic with occasional clears, in phases of varying bias
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        logic w;
        logic r;
        logic s;
        w = ($urandom_range(0, 9) < 3 + 2 * ph);
        r = ($urandom_range(0, 9) < 7 - 2 * ph);
        s = ($urandom_range(0, 59) == 0);
        step(w, 8'($urandom), r, s);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
